spart_driver: RTL and testbench
===============================

Name: spart_driver

Overview:
Bus-side initiator for the spart peripheral. It plays the processor role on the iocs/iorw/ioaddr/databus interface.
- After reset it programs the baud divisor from br_cfg.
- It then polls rda and tbr, reads received bytes into a 4-entry echo FIFO, and writes them back for transmission.
- It sits at top level beside spart and stands in for a CPU in board bring-up and loopback testing.

Parameters:
FIFO_DEPTH, 4, echo FIFO entries (power of two, ≥2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-low reset
br_cfg  in  2  baud select: 00=4800, 01=9600, 10=19200, 11=38400
rda  in  1  spart receive-data-available
tbr  in  1  spart transmit-buffer-ready
iocs  out  1  chip select, one-cycle strobes
iorw  out  1  1=read (spart drives databus), 0=write (driver drives)
ioaddr  out  2  00=data, 10=divisor low, 11=divisor high
databus  inout  8  driven by this block only while iocs=1 and iorw=0; otherwise high-Z
fifo_count  out  3  current echo FIFO occupancy
last_rx  out  8  last byte read from spart

Behaviour:
- Reset (rst=0 at clk edge):
  - Outputs: iocs=0, iorw=1, ioaddr=00, databus=Z, fifo_count=0, last_rx=8'h00.
  - State: FIFO pointers cleared, state=DIV_LO, br_cfg_q<=br_cfg.
  - Reset mid-transfer abandons the transfer; no partial push or pop is retained.
- Divisor table, 100 MHz clk, 16x oversample (value = 100e6/(16*baud) − 1):
  - 4800 → 16'h0515
  - 9600 → 16'h028A
  - 19200 → 16'h0145
  - 38400 → 16'h00A2
- DIV_LO: one cycle, iocs=1, iorw=0, ioaddr=10, databus=div[7:0] → DIV_HI.
- DIV_HI: one cycle, iocs=1, iorw=0, ioaddr=11, databus=div[15:8] → IDLE.
- IDLE: iocs=0, iorw=1. Priority order, evaluated each cycle:
  1. br_cfg != br_cfg_q → latch br_cfg_q, → DIV_LO. The FIFO contents are kept.
  2. rda=1 and FIFO not full → READ.
  3. tbr=1 and FIFO not empty → WRITE.
- READ: one cycle, iocs=1, iorw=1, ioaddr=00.
  - databus is sampled at the end of this cycle, pushed to the FIFO, and copied to last_rx.
  - Next state is RD_WAIT.
- RD_WAIT: one idle cycle so rda can deassert; no re-read of a stale rda → IDLE.
- WRITE: one cycle, iocs=1, iorw=0, ioaddr=00, databus=FIFO head; FIFO pops at the end of the cycle → WR_WAIT.
- WR_WAIT: one idle cycle so tbr can deassert → IDLE.
- Latency: a byte seen on rda at IDLE is on databus as a write no earlier than 3 cycles later (READ, RD_WAIT, IDLE→WRITE), provided tbr=1.
- FIFO full: rda is ignored and the byte stays held in spart. There is no overflow and no data loss.
- FIFO empty: tbr is ignored.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits. Full and empty are taken from MSB and index compare; wrap-around is modulo depth.
- Push and pop never occur in the same cycle because the FSM is single-transfer.
- iocs is never high for two consecutive cycles except for the DIV_LO→DIV_HI pair.
- ioaddr=01 is never issued.

Decomposition:
- Shared package spart_pkg:
  - state enum: DIV_LO, DIV_HI, IDLE, READ, RD_WAIT, WRITE, WR_WAIT
  - ioaddr constants: ADDR_DATA=2'b00, ADDR_DIV_LO=2'b10, ADDR_DIV_HI=2'b11
  - the four divisor constants and the br_cfg encoding
- One sub-module, echo_fifo: synchronous FIFO with ports push, pop, din, dout, full, empty, count; reset is synchronous active-low.

Test Plan:
1. rst low 2 cycles, br_cfg=01, release:
   - cycle 1: iocs=1, iorw=0, ioaddr=10, databus=8'h8A
   - cycle 2: ioaddr=11, databus=8'h02
   - then iocs=0, databus=Z
2. Model spart drives 8'h41 with rda=1, tbr=0:
   - one READ strobe (iocs=1, iorw=1, ioaddr=00)
   - last_rx=8'h41, fifo_count=1
   - no second read while rda is held through RD_WAIT, if the model drops rda in RD_WAIT
3. Set tbr=1 with the FIFO holding 8'h41: one WRITE strobe with databus=8'h41, iorw=0, ioaddr=00; fifo_count returns to 0.
4. tbr=0, five bytes 8'h10..8'h14 offered on rda:
   - four reads, fifo_count=4, the fifth byte is not read (rda stays 1)
   - raise tbr: writes appear in order 10, 11, 12, 13, then 14 is read and written
5. rda=1 and tbr=1 simultaneously with the FIFO holding one byte: READ occurs before WRITE.
6. Change br_cfg 01→11 while idle with 2 bytes buffered:
   - divisor rewritten as 8'hA2 then 8'h00
   - fifo_count stays 2 and the bytes are echoed afterwards
   - then assert rst mid-WRITE: iocs=0, databus=Z, fifo_count=0 on the next cycle

Source files
------------

// File: rtl/spart_pkg.sv
// Shared types and constants for the spart bus initiator: FSM states, bus
// addresses, baud divisors and the registered bus-strobe record.
package spart_pkg;

  typedef enum logic [2:0] {
    DIV_LO, DIV_HI, IDLE, READ, RD_WAIT, WRITE, WR_WAIT
  } state_t;

  localparam logic [1:0] ADDR_DATA   = 2'b00;
  localparam logic [1:0] ADDR_DIV_LO = 2'b10;
  localparam logic [1:0] ADDR_DIV_HI = 2'b11;

  localparam logic [1:0] BR_4800  = 2'b00;
  localparam logic [1:0] BR_9600  = 2'b01;
  localparam logic [1:0] BR_19200 = 2'b10;
  localparam logic [1:0] BR_38400 = 2'b11;

  // 100 MHz clock, 16x oversampling
  localparam logic [15:0] DIV_4800  = 16'h0515;
  localparam logic [15:0] DIV_9600  = 16'h028A;
  localparam logic [15:0] DIV_19200 = 16'h0145;
  localparam logic [15:0] DIV_38400 = 16'h00A2;

  typedef struct packed {
    logic       cs;
    logic       rw;
    logic [1:0] addr;
    logic [7:0] data;
  } bus_t;

  localparam bus_t BUS_IDLE = '{cs: 1'b0, rw: 1'b1, addr: ADDR_DATA, data: 8'h00};
  localparam bus_t BUS_READ = '{cs: 1'b1, rw: 1'b1, addr: ADDR_DATA, data: 8'h00};

  function automatic bus_t bus_wr(input logic [1:0] a, input logic [7:0] d);
    return '{cs: 1'b1, rw: 1'b0, addr: a, data: d};
  endfunction

  function automatic logic [15:0] div_for(input logic [1:0] cfg);
    case (cfg)
      BR_4800:  return DIV_4800;
      BR_9600:  return DIV_9600;
      BR_19200: return DIV_19200;
      default:  return DIV_38400;
    endcase
  endfunction

endpackage

// File: rtl/spart_driver_echo_fifo.sv
// Echo FIFO: power-of-two depth, pointers one bit wider than the index so
// full/empty fall out of an MSB + index compare.
module echo_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  r_wr_ptr, r_rd_ptr;
  logic [W-1:0] r_mem [DEPTH];
  logic         w_do_push, w_do_pop;

  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: a cleared pointer pair makes any stale entry unreachable.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
  end

  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                 (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign count = r_wr_ptr - r_rd_ptr;
  assign dout  = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/spart_driver.sv
// CPU stand-in for spart: programs the baud divisor, then polls rda/tbr and
// echoes every received byte back through a small FIFO.
module spart_driver
  import spart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [1:0]                    br_cfg,
  input  logic                          rda,
  input  logic                          tbr,
  output logic                          iocs,
  output logic                          iorw,
  output logic [1:0]                    ioaddr,
  inout  wire  [7:0]                    databus,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [7:0]                    last_rx
);
  state_t      r_state;
  bus_t        r_bus;
  logic [1:0]  r_br_cfg_q;
  logic [7:0]  r_last_rx;

  logic        w_full, w_empty, w_push, w_pop;
  logic [7:0]  w_head;
  logic [15:0] w_div_cur, w_div_new;

  assign w_div_cur = div_for(r_br_cfg_q);
  assign w_div_new = div_for(br_cfg);
  assign w_push    = (r_state == READ);
  assign w_pop     = (r_state == WRITE);

  // DIV_LO with cs low means "armed but not yet issued"; that is the state
  // reset leaves behind, so the first strobe lands one cycle after release.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= DIV_LO;
      r_bus      <= BUS_IDLE;
      r_br_cfg_q <= br_cfg;
      r_last_rx  <= 8'h00;
    end else begin
      r_bus <= BUS_IDLE;
      case (r_state)
        DIV_LO: begin
          if (!r_bus.cs) begin
            r_bus <= bus_wr(ADDR_DIV_LO, w_div_cur[7:0]);
          end else begin
            r_state <= DIV_HI;
            r_bus   <= bus_wr(ADDR_DIV_HI, w_div_cur[15:8]);
          end
        end
        DIV_HI: r_state <= IDLE;
        IDLE: begin
          if (br_cfg != r_br_cfg_q) begin
            r_br_cfg_q <= br_cfg;
            r_state    <= DIV_LO;
            r_bus      <= bus_wr(ADDR_DIV_LO, w_div_new[7:0]);
          end else if (rda && !w_full) begin
            r_state <= READ;
            r_bus   <= BUS_READ;
          end else if (tbr && !w_empty) begin
            r_state <= WRITE;
            r_bus   <= bus_wr(ADDR_DATA, w_head);
          end
        end
        READ: begin
          r_last_rx <= databus;
          r_state   <= RD_WAIT;
        end
        RD_WAIT: r_state <= IDLE;
        WRITE:   r_state <= WR_WAIT;
        WR_WAIT: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  echo_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (databus),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (fifo_count)
  );

  assign iocs    = r_bus.cs;
  assign iorw    = r_bus.rw;
  assign ioaddr  = r_bus.addr;
  assign last_rx = r_last_rx;
  assign databus = (r_bus.cs && !r_bus.rw) ? r_bus.data : 8'bz;

endmodule

// File: tb/tb_spart_driver.sv
// Bench for spart_driver: a behavioural spart model on the bus plus an echo
// scoreboard; divisor programming is swept from a vector table.
module tb_spart_driver;
  import spart_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] br_cfg = 2'b01;
  logic       rda = 1'b0;
  logic       tbr = 1'b0;
  logic       iocs, iorw;
  logic [1:0] ioaddr;
  wire  [7:0] databus;
  logic [2:0] fifo_count;
  logic [7:0] last_rx;
  logic [7:0] tb_drv = 8'h00;

  int checks = 0, failures = 0, rd_cnt = 0, wr_cnt = 0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  logic       prev_iocs = 1'b0;
  logic [1:0] prev_addr = 2'b00;

  typedef struct {
    logic [1:0] cfg;
    logic [7:0] lo;
    logic [7:0] hi;
  } div_vec_t;
  div_vec_t tbl[4];

  spart_driver #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .br_cfg(br_cfg), .rda(rda), .tbr(tbr),
    .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr), .databus(databus),
    .fifo_count(fifo_count), .last_rx(last_rx)
  );

  assign databus = (iocs && iorw) ? tb_drv : 8'bz;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // spart model + scoreboard, evaluated mid-cycle while DUT outputs are stable
  always @(negedge clk) begin
    if (iocs && prev_iocs)
      chk("iocs_pair_only_div", 32'(prev_addr == ADDR_DIV_LO && ioaddr == ADDR_DIV_HI), 1);
    if (iocs) chk("ioaddr_legal", 32'(ioaddr != 2'b01), 1);
    if (iocs && !iorw && ioaddr == ADDR_DATA) begin
      wr_cnt++;
      if (exp_q.size() == 0) chk("echo_unexpected", 32'(databus), 32'h100);
      else chk("echo_data", 32'(databus), 32'(exp_q.pop_front()));
    end
    if (iocs && iorw) begin
      rd_cnt++;
      if (rx_q.size() > 0) rx_q.delete(0);
      rda = 1'b0;
    end else begin
      rda    = (rx_q.size() > 0);
      tb_drv = rda ? rx_q[0] : 8'h00;
    end
    prev_iocs = iocs;
    prev_addr = ioaddr;
  end

  task automatic step(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic wait_cnt(input string name, input bit is_wr, input int target);
    int n = 0;
    while (((is_wr ? wr_cnt : rd_cnt) < target) && n < 100) begin step(1); n++; end
    chk(name, is_wr ? wr_cnt : rd_cnt, target);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, w0, n;
    tbl[0] = '{2'b00, 8'h15, 8'h05};
    tbl[1] = '{2'b10, 8'h45, 8'h01};
    tbl[2] = '{2'b11, 8'hA2, 8'h00};
    tbl[3] = '{2'b01, 8'h8A, 8'h02};

    // Divisor programming after reset for every baud select
    for (int i = 0; i < 4; i++) begin
      rst = 1'b0;
      br_cfg = tbl[i].cfg;
      repeat (2) @(posedge clk);
      step(1);
      chk("rst_iocs", iocs, 0);
      chk("rst_iorw", iorw, 1);
      chk("rst_ioaddr", ioaddr, 0);
      chk("rst_fifo_count", fifo_count, 0);
      chk("rst_last_rx", last_rx, 0);
      rst = 1'b1;
      step(1);
      chk("divlo_iocs", iocs, 1);
      chk("divlo_iorw", iorw, 0);
      chk("divlo_addr", ioaddr, 2'b10);
      chk("divlo_data", databus, tbl[i].lo);
      step(1);
      chk("divhi_iocs", iocs, 1);
      chk("divhi_addr", ioaddr, 2'b11);
      chk("divhi_data", databus, tbl[i].hi);
      step(1);
      chk("post_div_iocs", iocs, 0);
      chk("post_div_iorw", iorw, 1);
    end

    // Single byte read, rda dropped during the wait cycle
    rx_q.push_back(8'h41); exp_q.push_back(8'h41);
    wait_cnt("t2_read", 0, 1);
    step(4);
    chk("t2_single_read", rd_cnt, 1);
    chk("t2_last_rx", last_rx, 8'h41);
    chk("t2_fifo_count", fifo_count, 1);

    // Echo it back
    tbr = 1'b1;
    wait_cnt("t3_write", 1, 1);
    step(2);
    chk("t3_fifo_count", fifo_count, 0);
    tbr = 1'b0;

    // Fill to full; fifth byte held by spart until space opens
    for (int b = 8'h10; b <= 8'h14; b++) begin
      rx_q.push_back(8'(b)); exp_q.push_back(8'(b));
    end
    step(25);
    chk("t4_reads_when_full", rd_cnt, 5);
    chk("t4_fifo_full_count", fifo_count, 4);
    chk("t4_rda_held", rda, 1);
    tbr = 1'b1;
    wait_cnt("t4_writes", 1, 6);
    step(4);
    chk("t4_fifth_read", rd_cnt, 6);
    chk("t4_fifo_drained", fifo_count, 0);
    chk("t4_scoreboard_empty", exp_q.size(), 0);
    tbr = 1'b0;

    // rda and tbr together: read wins
    rx_q.push_back(8'h55); exp_q.push_back(8'h55);
    wait_cnt("t5_preload", 0, 7);
    step(3);
    chk("t5_fifo_one", fifo_count, 1);
    rx_q.push_back(8'h66); exp_q.push_back(8'h66);
    n = 0;
    while (!rda && n < 20) begin step(1); n++; end
    chk("t5_rda_up", rda, 1);
    tbr = 1'b1;
    r0 = rd_cnt; w0 = wr_cnt; n = 0;
    while (rd_cnt == r0 && wr_cnt == w0 && n < 20) begin step(1); n++; end
    chk("t5_first_is_read", rd_cnt, r0 + 1);
    chk("t5_no_write_first", wr_cnt, w0);
    wait_cnt("t5_writes", 1, w0 + 2);
    tbr = 1'b0;

    // Baud change with bytes buffered, then reset in the middle of a write
    rx_q.push_back(8'h77); exp_q.push_back(8'h77);
    rx_q.push_back(8'h88); exp_q.push_back(8'h88);
    wait_cnt("t6_reads", 0, rd_cnt + 2);
    step(3);
    br_cfg = 2'b11;
    step(1);
    chk("t6_divlo_iocs", iocs, 1);
    chk("t6_divlo_addr", ioaddr, 2'b10);
    chk("t6_divlo_data", databus, 8'hA2);
    step(1);
    chk("t6_divhi_addr", ioaddr, 2'b11);
    chk("t6_divhi_data", databus, 8'h00);
    step(1);
    chk("t6_idle_iocs", iocs, 0);
    chk("t6_fifo_kept", fifo_count, 2);
    w0 = wr_cnt;
    tbr = 1'b1;
    wait_cnt("t6_first_echo", 1, w0 + 1);
    wait_cnt("t6_second_echo", 1, w0 + 2);
    rst = 1'b0;
    step(1);
    chk("t6_rst_iocs", iocs, 0);
    chk("t6_rst_iorw", iorw, 1);
    chk("t6_rst_fifo", fifo_count, 0);
    chk("t6_rst_last_rx", last_rx, 0);
    tbr = 1'b0;
    rst = 1'b1;
    step(1);
    chk("t6_reprog_addr", ioaddr, 2'b10);
    chk("t6_reprog_data", databus, 8'hA2);
    step(3);
    chk("t6_scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
